// File: rtl/array_op_pkg.sv
// Shared types for the array-op scheduler: op encodings, FSM states and the 4-lane result array.
package array_op_pkg;

    localparam int unsigned LANES  = 4;
    localparam int unsigned DATA_W = 8;

    typedef enum logic [1:0] {
        OP_INC   = 2'b00,
        OP_SHL   = 2'b01,
        OP_LOGIC = 2'b10,
        OP_MISC  = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        HOLD = 2'b10
    } sched_state_e;

    // Lane 0 occupies the most significant byte.
    typedef logic [0:LANES-1][DATA_W-1:0] lane_arr_t;

endpackage

// File: rtl/array_op_unit.sv
// Combinational 4-lane array datapath; every lane result wraps modulo 256.
module array_op_unit
    import array_op_pkg::*;
(
    input  logic [DATA_W-1:0] data,
    input  op_e               op,
    output lane_arr_t         result
);

    always_comb begin
        result = '0;
        case (op)
            OP_INC: begin
                result[0] = data + 8'd1;
                result[1] = data + 8'd2;
                result[2] = data + 8'd3;
                result[3] = data + 8'd4;
            end
            OP_SHL: begin
                result[0] = data << 1;
                result[1] = data << 2;
                result[2] = data << 3;
                result[3] = data << 4;
            end
            OP_LOGIC: begin
                result[0] = ~data;
                result[1] = data & 8'hF0;
                result[2] = data | 8'h0F;
                result[3] = data ^ 8'hFF;
            end
            OP_MISC: begin
                result[0] = data;
                result[1] = {data[DATA_W-2:0], 1'b0};
                result[2] = data >> 1;
                result[3] = data % 8'd10;
            end
        endcase
    end

endmodule

// File: rtl/array_op_scheduler.sv
// Round-robin scheduler sharing one array_op_unit among NUM_REQ requesters (IDLE -> EXEC -> HOLD).
// Defining ARRAY_SCHED_STATS_EN adds per-requester saturating response counters on grant_cnt.
module array_op_scheduler
    import array_op_pkg::*;
#(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [NUM_REQ-1:0][DATA_W-1:0]   req_data,
    input  logic [NUM_REQ-1:0][1:0]          req_op,
    output logic                             rsp_valid,
    input  logic                             rsp_ready,
    output logic [ID_W-1:0]                  rsp_id,
    output lane_arr_t                        rsp_array,
    output logic                             busy
`ifdef ARRAY_SCHED_STATS_EN
    ,
    output logic [NUM_REQ-1:0][15:0]         grant_cnt
`endif
);

    sched_state_e      state_q, state_d;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   grant_idx;
    logic              grant_found;
    logic [DATA_W-1:0] data_q;
    op_e               op_q;
    logic [ID_W-1:0]   id_q;
    logic              accept, load_rsp, rsp_done;
    lane_arr_t         unit_result;

    function automatic logic [ID_W-1:0] wrap_idx(input logic [ID_W-1:0] base, input int unsigned off);
        int unsigned sum;
        sum = 32'(base) + off;
        if (sum >= NUM_REQ) sum = sum - NUM_REQ;
        return ID_W'(sum);
    endfunction

    // Search starts at rr_ptr so the last-served requester has lowest priority.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!grant_found && req_valid[wrap_idx(rr_ptr, i)]) begin
                grant_found = 1'b1;
                grant_idx   = wrap_idx(rr_ptr, i);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d   = state_q;
        req_ready = '0;
        accept    = 1'b0;
        load_rsp  = 1'b0;
        rsp_done  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!rst && grant_found) begin
                    req_ready[grant_idx] = 1'b1;
                    accept               = 1'b1;
                    state_d              = EXEC;
                end
            end
            EXEC: begin
                load_rsp = 1'b1;
                state_d  = HOLD;
            end
            HOLD: begin
                if (rsp_valid && rsp_ready) begin
                    rsp_done = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy = (state_q != IDLE);

    array_op_unit u_unit (
        .data   (data_q),
        .op     (op_q),
        .result (unit_result)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            data_q    <= '0;
            op_q      <= OP_INC;
            id_q      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_array <= '0;
        end else begin
            if (accept) begin
                data_q <= req_data[grant_idx];
                op_q   <= op_e'(req_op[grant_idx]);
                id_q   <= grant_idx;
            end
            if (load_rsp) begin
                rsp_array <= unit_result;
                rsp_id    <= id_q;
                rsp_valid <= 1'b1;
            end
            if (rsp_done) begin
                rsp_valid <= 1'b0;
                rr_ptr    <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
            end
        end
    end

`ifdef ARRAY_SCHED_STATS_EN
    // Counts completed response handshakes per owner, saturating.
    always_ff @(posedge clk) begin
        if (rst) begin
            grant_cnt <= '0;
        end else if (rsp_done && grant_cnt[rsp_id] != 16'hFFFF) begin
            grant_cnt[rsp_id] <= grant_cnt[rsp_id] + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_array_op_scheduler.sv
// Directed plus randomized bench for array_op_scheduler against an arithmetic reference model.
module tb_array_op_scheduler;

    localparam int N = 4;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [N-1:0]         req_valid;
    logic [N-1:0]         req_ready;
    logic [N-1:0][7:0]    req_data;
    logic [N-1:0][1:0]    req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [1:0]           rsp_id;
    array_op_pkg::lane_arr_t rsp_array;
    logic                 busy;
`ifdef ARRAY_SCHED_STATS_EN
    logic [N-1:0][15:0]   grant_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    int model_rr = 0;
    int model_cnt[N];

    always #5 clk = ~clk;

    array_op_scheduler #(.NUM_REQ(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .req_op    (req_op),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_array (rsp_array),
        .busy      (busy)
`ifdef ARRAY_SCHED_STATS_EN
        ,
        .grant_cnt (grant_cnt)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference results straight from the op table, lane 0 in the top byte.
    function automatic logic [31:0] model_lanes(input int d, input int op);
        int l[4];
        for (int k = 0; k < 4; k++) l[k] = 0;
        case (op)
            0: for (int k = 0; k < 4; k++) l[k] = d + k + 1;
            1: for (int k = 0; k < 4; k++) l[k] = d * (2 ** (k + 1));
            2: begin
                l[0] = 255 - d;
                l[1] = (d / 16) * 16;
                l[2] = (d / 16) * 16 + 15;
                l[3] = 255 - d;
            end
            default: begin
                l[0] = d;
                l[1] = d * 2;
                l[2] = d / 2;
                l[3] = d % 10;
            end
        endcase
        return {8'(l[0] % 256), 8'(l[1] % 256), 8'(l[2] % 256), 8'(l[3] % 256)};
    endfunction

    function automatic int model_grant(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(model_rr + k) % N]) return (model_rr + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        model_rr = 0;
        for (int i = 0; i < N; i++) model_cnt[i] = 0;
    endtask

    task automatic apply_reset();
        rst       = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("rst_ready", 32'(req_ready), 32'd0);
        rst = 1'b0;
        model_reset();
        check("rst_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
    endtask

    // One full request/response exchange; stall = cycles rsp_ready is held low in HOLD.
    task automatic run_txn(input logic [N-1:0] v, input logic [N-1:0][7:0] d,
                           input logic [N-1:0][1:0] o, input int stall, output int obs_id);
        int g;
        logic [31:0] exp_arr;
        req_valid = v;
        req_data  = d;
        req_op    = o;
        rsp_ready = (stall == 0);
        obs_id    = -1;
        #1;
        g = model_grant(v);
        if (g < 0) begin
            check("idle_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
            check("stay_idle", 32'(busy), 32'd0);
            return;
        end
        check("grant", 32'(req_ready), 32'(1 << g));
        check("accept_busy", 32'(busy), 32'd0);
        @(negedge clk);
        check("exec_ready", 32'(req_ready), 32'd0);
        check("exec_busy", 32'(busy), 32'd1);
        check("exec_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        exp_arr = model_lanes(int'(d[g]), int'(o[g]));
        obs_id  = int'(rsp_id);
        check("hold_valid", 32'(rsp_valid), 32'd1);
        check("hold_id", 32'(rsp_id), 32'(g));
        check("hold_array", 32'(rsp_array), exp_arr);
        for (int s = 1; s <= stall; s++) begin
            @(negedge clk);
            check("stall_valid", 32'(rsp_valid), 32'd1);
            check("stall_id", 32'(rsp_id), 32'(g));
            check("stall_array", 32'(rsp_array), exp_arr);
            check("stall_ready", 32'(req_ready), 32'd0);
            if (s == stall) rsp_ready = 1'b1;
        end
        @(negedge clk);
        check("done_valid", 32'(rsp_valid), 32'd0);
        check("done_busy", 32'(busy), 32'd0);
        model_rr = (g + 1) % N;
        model_cnt[g]++;
    endtask

    initial begin
        logic [N-1:0][7:0] d;
        logic [N-1:0][1:0] o;
        int id, prev_id;

        // Requests held high during reset must not be accepted.
        rst       = 1'b1;
        req_valid = '1;
        req_data  = '0;
        req_op    = '0;
        rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset_ready", 32'(req_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_valid", 32'(rsp_valid), 32'd0);
        check("reset_id", 32'(rsp_id), 32'd0);
        check("reset_array", 32'(rsp_array), 32'd0);
        req_valid = '0;
        rst       = 1'b0;
        model_reset();
        @(negedge clk);

        // All requesters persistently valid: strict rotation including the wrap.
        for (int i = 0; i < N; i++) begin
            d[i] = 8'(8'h10 * i + 1);
            o[i] = 2'(i);
        end
        prev_id = -1;
        for (int i = 0; i < 5; i++) begin
            run_txn('1, d, o, 0, id);
            check("rr_seq", 32'(id), 32'(i % N));
            check("no_repeat", 32'(id != prev_id), 32'd1);
            prev_id = id;
        end

        // Directed op coverage on requester 0.
        d = '0; o = '0;
        d[0] = 8'h05; o[0] = 2'b00; run_txn(4'b0001, d, o, 0, id);
        d[0] = 8'h81; o[0] = 2'b01; run_txn(4'b0001, d, o, 0, id);
        d[0] = 8'h3C; o[0] = 2'b10; run_txn(4'b0001, d, o, 0, id);
        d[0] = 8'hFF; o[0] = 2'b11; run_txn(4'b0001, d, o, 0, id);

        // Consumer back-pressure for 5 cycles.
        d[3] = 8'hA7; o[3] = 2'b11;
        run_txn(4'b1000, d, o, 5, id);

        // Reset while holding a result from requester 1 discards it.
        d[1] = 8'h22; o[1] = 2'b00;
        req_valid = 4'b0010; req_data = d; req_op = o; rsp_ready = 1'b0;
        #1;
        check("pre_rst_grant", 32'(req_ready), 32'h2);
        @(negedge clk);
        @(negedge clk);
        check("pre_rst_hold", 32'(rsp_valid), 32'd1);
        apply_reset();
        check("post_rst_id", 32'(rsp_id), 32'd0);
        check("post_rst_array", 32'(rsp_array), 32'd0);
        @(negedge clk);
        check("no_late_rsp", 32'(rsp_valid), 32'd0);
        run_txn('1, d, o, 0, id);
        check("rr_after_rst", 32'(id), 32'd0);
        d[2] = 8'h09; o[2] = 2'b11;
        run_txn(4'b0100, d, o, 0, id);
        check("req2_id", 32'(id), 32'd2);

`ifdef ARRAY_SCHED_STATS_EN
        apply_reset();
        for (int i = 0; i < 3; i++) run_txn(4'b0010, d, o, i, id);
        check("cnt1", 32'(grant_cnt[1]), 32'd3);
        check("cnt0", 32'(grant_cnt[0]), 32'd0);
        check("cnt2", 32'(grant_cnt[2]), 32'd0);
        check("cnt3", 32'(grant_cnt[3]), 32'd0);
        apply_reset();
        check("cnt_clr", 32'(grant_cnt), 32'd0);
        check("cnt_clr_hi", 32'(grant_cnt >> 32), 32'd0);
`endif

        // Random traffic, including requesters that come and go before being granted.
        for (int t = 0; t < 60; t++) begin
            for (int i = 0; i < N; i++) begin
                d[i] = 8'($urandom);
                o[i] = 2'($urandom);
            end
            run_txn(4'($urandom_range(0, 15)), d, o, int'($urandom_range(0, 3)), id);
        end

`ifdef ARRAY_SCHED_STATS_EN
        for (int i = 0; i < N; i++) check("cnt_final", 32'(grant_cnt[i]), 32'(model_cnt[i]));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
